// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: steps a 3-input circuit through all 8 vectors,
// captures Q into a truth table and compares it with a latched expected table.
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       q,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail
);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] idx, first_nx, first_w;
  logic [7:0] cnt, exp_l, cap, cap_nx;
  logic [3:0] cnt_w, cnt_w_nx;
  logic       miss;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? WAIT : IDLE;
      WAIT:    state_nx = (cnt == 8'd0) ? SAMPLE : WAIT;
      SAMPLE:  state_nx = (idx == 3'd7) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // Next working values include the current sample so DONE sees the full run.
  always_comb begin
    miss = q != exp_l[idx];
    cap_nx = cap;
    cap_nx[idx] = q;
    cnt_w_nx = cnt_w + {3'd0, miss};
    first_nx = (miss && cnt_w == 4'd0) ? idx : first_w;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      exp_l      <= '0;
      cap        <= '0;
      cnt_w      <= '0;
      first_w    <= '0;
      table_out  <= '0;
      pass       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_l   <= expected;
          idx     <= '0;
          cnt     <= 8'(SETTLE_CYCLES - 1);
          cap     <= '0;
          cnt_w   <= '0;
          first_w <= '0;
        end
        WAIT: if (cnt != 8'd0) cnt <= cnt - 8'd1;
        SAMPLE: begin
          cap     <= cap_nx;
          cnt_w   <= cnt_w_nx;
          first_w <= first_nx;
          idx     <= idx + 3'd1;
          cnt     <= 8'(SETTLE_CYCLES - 1);
          if (idx == 3'd7) begin
            table_out  <= cap_nx;
            fail_count <= cnt_w_nx;
            first_fail <= first_nx;
            pass       <= cnt_w_nx == 4'd0;
          end
        end
        default: ;
      endcase
    end
  assign {a, b, c} = idx;
  assign busy = (state == WAIT) || (state == SAMPLE);
  assign done = state == DONE;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed tests on two instances (settle 4 and settle 1).
module tb_truth_table_sequencer;
  logic clk = 0, rst_n = 0;
  logic [7:0] expected = 8'hE8;
  logic start4 = 0, start1 = 0;
  logic [1:0] qmode4 = 0;
  logic a4, b4, c4, busy4, done4, pass4, q4;
  logic a1, b1, c1, busy1, done1, pass1, q1;
  logic [7:0] tab4, tab1;
  logic [3:0] fc4, fc1;
  logic [2:0] ff4, ff1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // qmode: 0 = majority, 1 = stuck at 0, 2 = stuck at 1
  assign q4 = (qmode4 == 2'd0) ? ((a4 & b4) | (a4 & c4) | (b4 & c4)) : (qmode4 == 2'd2);
  assign q1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  truth_table_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .expected(expected), .q(q4),
    .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .table_out(tab4),
    .pass(pass4), .fail_count(fc4), .first_fail(ff4));

  truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected), .q(q1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .table_out(tab1),
    .pass(pass1), .fail_count(fc1), .first_fail(ff1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept a start on dut4, then count edges after E0 until done (bounded).
  task automatic run4(output int n, output logic busy_e0);
    start4 = 1;
    tick;
    busy_e0 = busy4;
    start4 = 0;
    n = 0;
    while (!done4 && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({a4, b4, c4, busy4, done4, tab4, pass4, fc4, ff4} !== 22'd0) begin
      errors++;
      $display("FAIL %s dut4: got abc=%b busy=%b done=%b tab=%h pass=%b fc=%0d ff=%0d, expected all 0",
               tag, {a4, b4, c4}, busy4, done4, tab4, pass4, fc4, ff4);
    end
    checks++;
    if ({a1, b1, c1, busy1, done1, tab1, pass1, fc1, ff1} !== 22'd0) begin
      errors++;
      $display("FAIL %s dut1: got abc=%b busy=%b done=%b tab=%h pass=%b fc=%0d ff=%0d, expected all 0",
               tag, {a1, b1, c1}, busy1, done1, tab1, pass1, fc1, ff1);
    end
  endtask

  task automatic test_reset;
    #2;
    check_reset_vals("reset");
    tick;
    rst_n = 1;
    tick;
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_majority;
    int n;
    logic be;
    qmode4 = 0;
    expected = 8'hE8;
    run4(n, be);
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL maj_busy_e0: got %b expected 1", be); end
    checks++; if (n !== 40) begin errors++; $display("FAIL maj_latency: got %0d expected 40", n); end
    checks++; if (tab4 !== 8'hE8) begin errors++; $display("FAIL maj_table: got %h expected e8", tab4); end
    checks++; if (pass4 !== 1'b1) begin errors++; $display("FAIL maj_pass: got %b expected 1", pass4); end
    checks++; if (fc4 !== 4'd0) begin errors++; $display("FAIL maj_fail_count: got %0d expected 0", fc4); end
    checks++; if (ff4 !== 3'd0) begin errors++; $display("FAIL maj_first_fail: got %0d expected 0", ff4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL maj_busy_done: got %b expected 0", busy4); end
    tick;
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL maj_done_pulse: got %b expected 0", done4); end
  endtask

  task automatic test_stuck0;
    int n;
    logic be;
    qmode4 = 1;
    expected = 8'hE8;
    run4(n, be);
    checks++; if (n !== 40) begin errors++; $display("FAIL s0_latency: got %0d expected 40", n); end
    checks++; if (tab4 !== 8'h00) begin errors++; $display("FAIL s0_table: got %h expected 00", tab4); end
    checks++; if (pass4 !== 1'b0) begin errors++; $display("FAIL s0_pass: got %b expected 0", pass4); end
    checks++; if (fc4 !== 4'd4) begin errors++; $display("FAIL s0_fail_count: got %0d expected 4", fc4); end
    checks++; if (ff4 !== 3'd3) begin errors++; $display("FAIL s0_first_fail: got %0d expected 3", ff4); end
    tick;
  endtask

  task automatic test_sequence;
    logic [2:0] exp_abc;
    expected = 8'hE8;
    start1 = 1;
    tick;
    start1 = 0;
    for (int i = 0; i < 16; i++) begin
      exp_abc = 3'(i / 2);
      checks++;
      if ({a1, b1, c1} !== exp_abc || done1 !== 1'b0) begin
        errors++;
        $display("FAIL seq_abc[%0d]: got abc=%b done=%b expected abc=%b done=0", i, {a1, b1, c1}, done1, exp_abc);
      end
      tick;
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL seq_done_16: got %b expected 1", done1); end
    checks++; if ({a1, b1, c1} !== 3'b000) begin errors++; $display("FAIL seq_abc_done: got %b expected 000", {a1, b1, c1}); end
    checks++; if (tab1 !== 8'hE8 || pass1 !== 1'b1) begin errors++; $display("FAIL seq_result: got tab=%h pass=%b expected e8 1", tab1, pass1); end
    tick;
  endtask

  task automatic test_ignore_start;
    int dones;
    qmode4 = 0;
    expected = 8'hE8;
    start4 = 1;
    tick;
    start4 = 0;
    expected = 8'h00;
    dones = 0;
    for (int n = 0; n < 60; n++) begin
      start4 = (n <= 39) && (n % 3 == 0);
      if (done4) dones++;
      tick;
    end
    start4 = 0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
    checks++; if (tab4 !== 8'hE8 || pass4 !== 1'b1) begin errors++; $display("FAIL ign_result: got tab=%h pass=%b expected e8 1", tab4, pass4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b expected 0", busy4); end
    expected = 8'hE8;
  endtask

  task automatic test_abort_reset;
    int n;
    logic be;
    logic saw_done;
    qmode4 = 0;
    start4 = 1;
    tick;
    start4 = 0;
    saw_done = 0;
    for (int i = 0; i < 26; i++) begin
      if (done4) saw_done = 1;
      tick;
    end
    checks++; if ({a4, b4, c4} !== 3'd5) begin errors++; $display("FAIL abort_idx5: got %b expected 101", {a4, b4, c4}); end
    #2 rst_n = 0;
    #1;
    check_reset_vals("abort_reset");
    tick;
    tick;
    check_reset_vals("abort_hold");
    #2 rst_n = 1;
    for (int i = 0; i < 45; i++) begin
      if (done4) saw_done = 1;
      tick;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
    run4(n, be);
    checks++; if (n !== 40) begin errors++; $display("FAIL abort_rerun_latency: got %0d expected 40", n); end
    checks++; if (tab4 !== 8'hE8 || pass4 !== 1'b1) begin errors++; $display("FAIL abort_rerun_result: got tab=%h pass=%b expected e8 1", tab4, pass4); end
    tick;
  endtask

  task automatic test_back_to_back;
    int n;
    qmode4 = 1;
    run4(n, n[0]);
    tick;
    qmode4 = 0;
    expected = 8'hE8;
    start4 = 1;
    tick;
    n = 0;
    while (!done4 && n < 200) begin
      tick;
      n++;
    end
    checks++; if (n !== 40 || pass4 !== 1'b1) begin errors++; $display("FAIL b2b_run1: got lat=%0d pass=%b expected 40 1", n, pass4); end
    qmode4 = 2;
    tick;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", busy4, done4); end
    tick;
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b expected 1", busy4); end
    start4 = 0;
    n = 0;
    while (!done4 && n < 200) begin
      if (n == 20 && (tab4 !== 8'hE8 || pass4 !== 1'b1)) begin
        errors++;
        $display("FAIL b2b_held: got tab=%h pass=%b expected e8 1", tab4, pass4);
      end
      if (n == 20) checks++;
      tick;
      n++;
    end
    checks++; if (n !== 40) begin errors++; $display("FAIL b2b_latency2: got %0d expected 40", n); end
    checks++; if (tab4 !== 8'hFF) begin errors++; $display("FAIL b2b_table2: got %h expected ff", tab4); end
    checks++; if (fc4 !== 4'd4) begin errors++; $display("FAIL b2b_fail_count2: got %0d expected 4", fc4); end
    checks++; if (ff4 !== 3'd0 || pass4 !== 1'b0) begin errors++; $display("FAIL b2b_first_fail2: got ff=%0d pass=%b expected 0 0", ff4, pass4); end
    tick;
  endtask

  initial begin
    test_reset;
    test_majority;
    test_stuck0;
    test_sequence;
    test_ignore_start;
    test_abort_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Controller that drives the 3-input combinational circuit (inputs A, B, C; output Q) through all eight input combinations. It holds each vector for a programmable settle time and samples Q into an 8-bit captured truth table. It compares the capture against an expected table and reports pass/fail. It replaces hand-written stimulus sequencing with a synthesizable start/busy/done engine that sits between a control source and the circuit under exercise.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles each vector is held in WAIT before the sample cycle; legal range 1..255.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  run request; honoured only in IDLE.
- expected  input  8  expected Q per vector; bit i = Q for {A,B,C} = i. Latched at start acceptance.
- q  input  1  Q output of the combinational circuit.
- a, b, c  output  1 each  drive circuit inputs A, B, C.
- busy  output  1  high from start acceptance until the last sample.
- done  output  1  one-cycle pulse; results valid from this cycle.
- table_out  output  8  captured Q per vector, bit i = vector i.
- pass  output  1  1 when table_out == latched expected.
- fail_count  output  4  number of mismatching vectors, 0..8.
- first_fail  output  3  lowest mismatching index; 0 when pass = 1.

## Operation
- Vector index idx is a 3-bit register: a = idx[2], b = idx[1], c = idx[0]. In IDLE and DONE, idx = 0, so abc = 000.
- FSM states:
  - IDLE: when start = 1, latch expected, idx = 0, settle counter = SETTLE_CYCLES-1, clear the working capture, mismatch count and first-fail registers, then go to WAIT.
  - WAIT: decrement the counter. Go to SAMPLE on the edge where the counter is 0.
  - SAMPLE: at the edge leaving SAMPLE:
    - write q into working capture bit idx;
    - on q != expected_latched[idx], increment the working count; on the first mismatch of the run, also record idx as first-fail;
    - if idx == 7, go to DONE;
    - otherwise idx+1, reload the counter, go to WAIT.
  - DONE: copy the working registers to table_out, fail_count and first_fail, and set pass = (count == 0). Assert done for this cycle, then go to IDLE.
- Result outputs change only on entry to DONE. Previous results are held throughout a run.
- busy = 1 in WAIT and SAMPLE; busy = 0 in IDLE and DONE.
- start in WAIT, SAMPLE or DONE is ignored with no queuing. Changes to expected after acceptance are ignored.
- fail_count saturates naturally at 8; there is no wrap.

## Timing
- Reset (asynchronous, immediate) values:
  - a = b = c = 0, busy = 0, done = 0;
  - table_out = 0x00, pass = 0, fail_count = 0, first_fail = 0;
  - state IDLE.
- Reset asserted mid-run aborts the run: no done, results cleared to the reset values.
- Let E0 be the edge sampling start = 1 in IDLE. busy rises after E0.
- Each vector occupies SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in WAIT plus 1 in SAMPLE.
- q is sampled at the end of the SAMPLE cycle. abc has then been stable for SETTLE_CYCLES + 1 edges.
- DONE occupies the cycle after edge E0 + 8·(SETTLE_CYCLES+1). Example: SETTLE_CYCLES = 4 gives done in the cycle after E0 + 40.
- With start held high, the earliest next acceptance is the first IDLE cycle after DONE. Back-to-back runs are therefore separated by exactly one IDLE cycle.

## Test plan
- Q modelled as majority(A,B,C), expected = 0xE8, SETTLE_CYCLES = 4 → done pulses once, 40 edges after E0, with table_out = 0xE8, pass = 1, fail_count = 0, first_fail = 0.
- q stuck at 0, expected = 0xE8 → table_out = 0x00, pass = 0, fail_count = 4, first_fail = 3.
- Sequence check with SETTLE_CYCLES = 1 → abc steps 000, 001, …, 111, each held exactly 2 cycles; done 16 edges after E0; abc = 000 after done.
- Start pulsed repeatedly while busy, and expected changed to 0x00 mid-run (majority model) → exactly one done; results match the latched 0xE8 (pass = 1).
- rst_n pulsed low while idx = 5 → all outputs take reset values immediately with no done. A subsequent start runs all 8 vectors from idx 0 with full latency.
- start held high for two runs: run 1 uses majority/0xE8, run 2 uses q stuck at 1 with expected 0xE8 → run 1 results (pass = 1) held through run 2. After run 2 done: table_out = 0xFF, fail_count = 4, first_fail = 0. One IDLE cycle between done and the second busy.
